// File: rtl/load_align_unit.sv
// load_align_unit: sequential load path that issues one or two aligned reads and registers the extended result.
// Optional feature macro LOAD_MISALIGN_EN: straddling loads are split into two beats instead of faulting.
`timescale 1ns/1ps
`default_nettype none

module load_align_unit #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_width,
   input  logic [DATA_W-1:0] req_alu_res,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_fault
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ0  = 3'd1;
   localparam logic [2:0] S_WAIT0 = 3'd2;
`ifdef LOAD_MISALIGN_EN
   localparam logic [2:0] S_REQ1  = 3'd3;
   localparam logic [2:0] S_WAIT1 = 3'd4;
`endif
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [2:0] W_PASS = 3'b000;
   localparam logic [2:0] W_D    = 3'b001;
   localparam logic [2:0] W_W    = 3'b010;
   localparam logic [2:0] W_H    = 3'b011;
   localparam logic [2:0] W_B    = 3'b100;
   localparam logic [2:0] W_WU   = 3'b101;
   localparam logic [2:0] W_HU   = 3'b110;
   localparam logic [2:0] W_BU   = 3'b111;

   logic [2:0]        r_state;
   logic [2:0]        r_width;
   logic [OFF_W-1:0]  r_off;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_fault;
`ifdef LOAD_MISALIGN_EN
   logic [DATA_W-1:0] r_beat0;
   logic              r_straddle;
`endif

   logic [OFF_W-1:0]  w_off;
   logic [4:0]        w_end;
   logic              w_straddle;
   logic              w_illegal;
   logic              w_fault;
   logic [ADDR_W-1:0] w_base;

   function automatic logic [4:0] f_size(input logic [2:0] w);
      case (w)
         W_D:        f_size = 5'd8;
         W_W, W_WU:  f_size = 5'd4;
         W_H, W_HU:  f_size = 5'd2;
         default:    f_size = 5'd1;
      endcase
   endfunction

   // Shift the two-beat window down to the addressed byte, keep sz bytes, then extend.
   function automatic logic [DATA_W-1:0] f_extract(input logic [2*DATA_W-1:0] cat,
                                                   input logic [OFF_W-1:0]    off,
                                                   input logic [2:0]          w);
      logic [DATA_W-1:0] low;
      logic [DATA_W-1:0] mask;
      logic              sbit;
      logic              sgn;
      low = DATA_W'(cat >> {off, 3'b000});
      case (w)
         W_B, W_BU: begin mask = DATA_W'(8'hFF);         sbit = low[7];  end
         W_H, W_HU: begin mask = DATA_W'(16'hFFFF);      sbit = low[15]; end
         W_W, W_WU: begin mask = DATA_W'(32'hFFFF_FFFF); sbit = low[31]; end
         default:   begin mask = '1;                     sbit = 1'b0;    end
      endcase
      sgn = (w == W_B) || (w == W_H) || (w == W_W);
      f_extract = (low & mask) | ((sgn && sbit) ? ~mask : '0);
   endfunction

   assign w_off      = req_addr[OFF_W-1:0];
   assign w_end      = 5'(w_off) + f_size(req_width);
   assign w_straddle = w_end > 5'(BYTES);
   assign w_illegal  = (req_width == W_D) && (DATA_W == 32);
   assign w_base     = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef LOAD_MISALIGN_EN
   assign w_fault    = w_illegal;
`else
   assign w_fault    = w_illegal | w_straddle;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_width     <= '0;
         r_off       <= '0;
         r_mem_addr  <= '0;
         r_rsp_data  <= '0;
         r_rsp_fault <= 1'b0;
`ifdef LOAD_MISALIGN_EN
         r_beat0     <= '0;
         r_straddle  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_width <= req_width;
                  r_off   <= w_off;
                  if (req_width == W_PASS) begin
                     r_rsp_data  <= req_alu_res;
                     r_rsp_fault <= 1'b0;
                     r_state     <= S_DONE;
                  end else if (w_fault) begin
                     r_rsp_data  <= '0;
                     r_rsp_fault <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_mem_addr <= w_base;
`ifdef LOAD_MISALIGN_EN
                     r_straddle <= w_straddle;
`endif
                     r_state    <= S_REQ0;
                  end
               end
            end
            S_REQ0: begin
               if (mem_req_ready) r_state <= S_WAIT0;
            end
            S_WAIT0: begin
               if (mem_rsp_valid) begin
`ifdef LOAD_MISALIGN_EN
                  r_beat0 <= mem_rdata;
                  if (r_straddle) begin
                     r_mem_addr <= r_mem_addr + ADDR_W'(BYTES);
                     r_state    <= S_REQ1;
                  end else begin
                     r_rsp_data  <= f_extract({{DATA_W{1'b0}}, mem_rdata}, r_off, r_width);
                     r_rsp_fault <= 1'b0;
                     r_state     <= S_DONE;
                  end
`else
                  r_rsp_data  <= f_extract({{DATA_W{1'b0}}, mem_rdata}, r_off, r_width);
                  r_rsp_fault <= 1'b0;
                  r_state     <= S_DONE;
`endif
               end
            end
`ifdef LOAD_MISALIGN_EN
            S_REQ1: begin
               if (mem_req_ready) r_state <= S_WAIT1;
            end
            S_WAIT1: begin
               if (mem_rsp_valid) begin
                  r_rsp_data  <= f_extract({mem_rdata, r_beat0}, r_off, r_width);
                  r_rsp_fault <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready     = (r_state == S_IDLE);
`ifdef LOAD_MISALIGN_EN
   assign mem_req_valid = (r_state == S_REQ0) || (r_state == S_REQ1);
`else
   assign mem_req_valid = (r_state == S_REQ0);
`endif
   assign mem_addr      = r_mem_addr;
   assign rsp_valid     = (r_state == S_DONE);
   assign rsp_data      = r_rsp_data;
   assign rsp_fault     = r_rsp_fault;

endmodule

`default_nettype wire

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: scoreboard bench with a byte-level memory reference model and a reactive memory.
// Honours LOAD_MISALIGN_EN the same way the design does.
`timescale 1ns/1ps
`default_nettype none

module tb_load_align_unit;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        req_width;
   logic [DATA_W-1:0] req_alu_res;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_fault;

   always #5 clk = ~clk;

   load_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_width(req_width), .req_alu_res(req_alu_res),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault)
   );

   typedef struct {
      logic [63:0] data;
      logic        fault;
      bit          mem;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] addr_q[$];
   logic [63:0] mem_tab[logic [63:0]];

   int n_checks = 0;
   int n_pass   = 0;

   // environment controls
   bit          fast      = 1'b1;
   bit          hold_rsp  = 1'b0;
   bit          rdy_rand  = 1'b0;
   bit          rdy_force = 1'b1;
   int          req_cnt   = 0;
   int          rsp_cnt   = 0;
   int          stale_req = 0;
   int          stale_done = 0;
   int          pend_delay = 0;
   logic [63:0] pend_addr  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
   endtask

   task automatic fail_now(input string name, input logic [63:0] val);
      n_checks++;
      $display("FAIL %s: got 0x%h, expected none", name, val);
   endtask

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      if (mem_tab.exists(a)) return mem_tab[a];
      return {a[31:0] ^ 32'hC3A5_5A3C, a[34:3] * 32'h9E37_79B1};
   endfunction

   // Byte-addressed view of memory: gather sz little-endian bytes starting at a, then extend.
   function automatic void ref_load(input logic [63:0] a, input logic [2:0] w, input logic [63:0] alu,
                                    output logic [63:0] d, output logic f, output int nbeats);
      int sz;
      bit sgn;
      logic [63:0] ba;
      logic [63:0] wd;
      d = '0; f = 1'b0; nbeats = 0;
      if (w == 3'b000) begin
         d = alu;
         return;
      end
      case (w)
         3'b001:         sz = 8;
         3'b010, 3'b101: sz = 4;
         3'b011, 3'b110: sz = 2;
         default:        sz = 1;
      endcase
      sgn = (w >= 3'b001) && (w <= 3'b100);
      if (int'(a[2:0]) + sz > 8) begin
`ifdef LOAD_MISALIGN_EN
         nbeats = 2;
`else
         f = 1'b1;
         return;
`endif
      end else begin
         nbeats = 1;
      end
      for (int i = 0; i < sz; i++) begin
         ba = a + 64'(i);
         wd = mem_word({ba[63:3], 3'b000});
         d[8*i +: 8] = wd[8*ba[2:0] +: 8];
      end
      if (sgn && sz < 8 && d[8*sz-1])
         for (int i = 8*sz; i < 64; i++) d[i] = 1'b1;
   endfunction

   task automatic issue(input logic [63:0] a, input logic [2:0] w, input logic [63:0] alu);
      exp_t        e;
      logic [63:0] d;
      logic        f;
      int          nb;
      int          guard;
      @(negedge clk);
      req_valid = 1'b1; req_addr = a; req_width = w; req_alu_res = alu;
      guard = 0;
      while (!req_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         fail_now("accept_timeout", a);
         req_valid = 1'b0;
         return;
      end
      ref_load(a, w, alu, d, f, nb);
      e.data = d; e.fault = f; e.mem = (nb != 0);
      exp_q.push_back(e);
      if (nb >= 1) addr_q.push_back({a[63:3], 3'b000});
      if (nb == 2) addr_q.push_back({a[63:3], 3'b000} + 64'd8);
      @(posedge clk);
      #2;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || !req_ready) && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // Reactive memory and response-ready driver; all inputs change on the falling edge.
   int wait_cnt = 0;
   initial begin
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (rst) wait_cnt = 0;
         if (stale_req != stale_done) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = {$urandom, $urandom};
            stale_done    = stale_req;
         end else if (req_cnt != rsp_cnt && !hold_rsp) begin
            if (wait_cnt >= pend_delay) begin
               mem_rsp_valid = 1'b1;
               mem_rdata     = mem_word(pend_addr);
               rsp_cnt++;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
         mem_req_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
         rsp_ready     = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
      end
   end

   // Monitor: samples 1 ns after each rising edge and scores against the queues.
   logic        p_req_ready = 1'b0, p_mem_req_valid = 1'b0, p_rsp_valid = 1'b0, p_rsp_fault = 1'b0;
   logic [63:0] p_mem_addr = '0, p_rsp_data = '0;
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            exp_q.delete();
            addr_q.delete();
            req_cnt = rsp_cnt;
         end else begin
            if (p_mem_req_valid && mem_req_ready) begin
               check("one_outstanding", 64'(req_cnt != rsp_cnt), 64'd0);
               if (addr_q.size() == 0) fail_now("unexpected_mem_req", p_mem_addr);
               else check("mem_addr", p_mem_addr, addr_q.pop_front());
               pend_addr  = p_mem_addr;
               pend_delay = fast ? 0 : $urandom_range(0, 3);
               req_cnt++;
            end
            if (p_rsp_valid && rsp_ready) begin
               check("done_exit", 64'(rsp_valid), 64'd0);
            end else if (p_rsp_valid) begin
               check("hold_valid", 64'(rsp_valid), 64'd1);
               check("hold_data", rsp_data, p_rsp_data);
               check("hold_fault", 64'(rsp_fault), 64'(p_rsp_fault));
            end
            if (rsp_valid && !p_rsp_valid) begin
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_rsp", rsp_data);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_data", rsp_data, e.data);
                  check("rsp_fault", 64'(rsp_fault), 64'(e.fault));
                  if (e.mem) check("latency_mem", 64'(mem_rsp_valid), 64'd1);
                  else       check("latency_imm", 64'(req_valid && p_req_ready), 64'd1);
               end
            end
         end
         p_req_ready = req_ready; p_mem_req_valid = mem_req_valid; p_mem_addr = mem_addr;
         p_rsp_valid = rsp_valid; p_rsp_data = rsp_data; p_rsp_fault = rsp_fault;
      end
   end

   initial begin
      logic [63:0] a;
      logic [2:0]  w;
      int          guard;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_width = '0; req_alu_res = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", rsp_data, 64'd0);
      check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
      rst = 1'b0;

      mem_tab[64'h1000] = 64'h80FF_0000_0000_0000;
      mem_tab[64'h2000] = 64'hDEAD_BEEF_0000_0000;
      mem_tab[64'h3000] = 64'h1122_3344_5566_7788;
      mem_tab[64'h3008] = 64'h99AA_BBCC_DDEE_FF00;
      issue(64'h1007, 3'b100, 64'h0);
      issue(64'h2004, 3'b101, 64'h0);
      issue(64'h3006, 3'b001, 64'h0);
      issue(64'h1001, 3'b011, 64'h0);
      wait_idle();

      // Result held while the consumer stalls for three cycles.
      @(posedge clk); #2; rdy_force = 1'b0;
      issue(64'h0, 3'b000, 64'h1234);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_valid", 64'(rsp_valid), 64'd1);
         check("stall_data", rsp_data, 64'h1234);
         if (i == 2) begin
            @(posedge clk); #2; rdy_force = 1'b1;
         end
      end
      @(negedge clk);
      check("stall_release", 64'(rsp_valid), 64'd0);
      issue(64'h8, 3'b000, 64'hCAFE_F00D);
      wait_idle();

      // Reset while waiting for read data, then a stale response.
      hold_rsp = 1'b1;
      issue(64'h4000, 3'b010, 64'h0);
      guard = 0;
      while (req_cnt == rsp_cnt && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("wait0_reached", 64'(req_cnt != rsp_cnt), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; hold_rsp = 1'b0; stale_req++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
         check("post_rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      end
      check("post_rst_req_ready", 64'(req_ready), 64'd1);
      check("post_rst_mem_addr", mem_addr, 64'd0);
      check("post_rst_rsp_data", rsp_data, 64'd0);
      check("post_rst_rsp_fault", 64'(rsp_fault), 64'd0);

      // Randomised traffic with variable memory latency and back-pressure.
      fast = 1'b0; rdy_rand = 1'b1;
      for (int n = 0; n < 300; n++) begin
         a = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) a[63:3] = '1;
         w = 3'($urandom_range(0, 7));
         issue(a, w, {$urandom, $urandom});
      end
      wait_idle();
      check("addr_q_empty", 64'(addr_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      fail_now("global_timeout", 64'(exp_q.size()));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "simulation did not complete");
   end

endmodule

`default_nettype wire
